// File: rtl/vive_tx_scheduler.sv
// vive_tx_scheduler
//   Round-robin arbiter and serialiser that shares one serial link between
//   NCH lighthouse sensor channels. One measurement is latched per frame.
//   The frame goes out as {channel id, measurement, even parity}, MSB first.
//   Frames are separated by an optional idle gap.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   req_valid    per-channel measurement available
//   req_data     channel i occupies bits [i*DW +: DW]
//   req_ready    one-hot grant; a transfer happens when valid & ready at a clk edge
//   transmission high for the duration of a frame
//   clock        serial clock (low half first, CLK_DIV cycles per half)
//   data         serial data, changes only while clock is low
//   busy         high whenever the scheduler is not idle
//   grant_id     id of the channel currently or last transmitted
//   frame_cnt    completed frames, wraps 255 -> 0
module vive_tx_scheduler #(
  parameter int NCH     = 4,
  parameter int ID_W    = 2,
  parameter int DW      = 16,
  parameter int CLK_DIV = 8,
  parameter int GAP     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic              transmission,
  output logic              clock,
  output logic              data,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic [7:0]        frame_cnt
);

  localparam int NBITS   = ID_W + DW + 1;
  localparam int BW      = $clog2(NBITS);
  localparam int DVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_CYC = GAP * 2 * CLK_DIV;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [NBITS-1:0]   shreg_q;
  logic [DVW-1:0]     div_q;
  logic [BW-1:0]      bit_q;
  logic [GW-1:0]      gap_q;
  logic               tx_q;
  logic               clk_q;
  logic               data_q;
  logic [ID_W-1:0]    grant_q;
  logic [7:0]         fcnt_q;

  logic [DW-1:0]      req_word [NCH];

  // Arbitration results (combinational)
  logic               found_hi, found_lo, arb_found;
  logic [ID_W-1:0]    hi_idx, lo_idx, arb_idx;
  logic [DW-1:0]      hi_data, lo_data, arb_data;
  logic [ID_W-1:0]    ptr_d;
  logic [NBITS-1:0]   frame_d;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign req_word[gi]  = req_data[gi*DW +: DW];
      assign req_ready[gi] = (state_q == S_IDLE) && !rst && arb_found &&
                             (arb_idx == ID_W'(gi));
    end
  endgenerate

  // Rotating priority as two passes: channels ptr..NCH-1 first, then 0..ptr-1.
  // The wrap-around pass only matters when the upper pass finds nothing.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_data  = '0;
    lo_data  = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!found_hi && req_valid[j] && (ID_W'(j) >= ptr_q)) begin
        found_hi = 1'b1;
        hi_idx   = ID_W'(j);
        hi_data  = req_word[j];
      end
      if (!found_lo && req_valid[j]) begin
        found_lo = 1'b1;
        lo_idx   = ID_W'(j);
        lo_data  = req_word[j];
      end
    end
    arb_found = found_hi || found_lo;
    arb_idx   = found_hi ? hi_idx  : lo_idx;
    arb_data  = found_hi ? hi_data : lo_data;
    ptr_d     = (arb_idx == ID_W'(NCH - 1)) ? '0 : arb_idx + 1'b1;
    frame_d   = {arb_idx, arb_data, ^{arb_idx, arb_data}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= 1'b0;
      clk_q   <= 1'b0;
      data_q  <= 1'b0;
      grant_q <= '0;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arb_found) begin
            // First bit goes straight onto the line; the shift register keeps
            // the remaining bits left-aligned.
            data_q  <= frame_d[NBITS-1];
            shreg_q <= frame_d << 1;
            tx_q    <= 1'b1;
            clk_q   <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            grant_q <= arb_idx;
            ptr_q   <= ptr_d;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (div_q == DVW'(CLK_DIV - 1)) begin
            div_q <= '0;
            if (!clk_q) begin
              clk_q <= 1'b1;
            end else begin
              // End of the high phase is the bit boundary.
              clk_q <= 1'b0;
              if (bit_q == BW'(NBITS - 1)) begin
                tx_q    <= 1'b0;
                data_q  <= 1'b0;
                fcnt_q  <= fcnt_q + 8'd1;
                gap_q   <= '0;
                state_q <= (GAP == 0) ? S_IDLE : S_GAP;
              end else begin
                bit_q   <= bit_q + 1'b1;
                data_q  <= shreg_q[NBITS-1];
                shreg_q <= shreg_q << 1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_GAP: begin
          if (int'(gap_q) == GAP_CYC - 1) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign transmission = tx_q;
  assign clock        = clk_q;
  assign data         = data_q;
  assign busy         = (state_q != S_IDLE);
  assign grant_id     = grant_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_vive_tx_scheduler.sv
module tb_vive_tx_scheduler;

  typedef struct {
    logic [1:0]  id;
    logic [18:0] bits;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: CLK_DIV=2, GAP=4
  logic        rst_a = 1'b1;
  logic [3:0]  valid_a = '0;
  logic [63:0] data_a = '0;
  logic [3:0]  ready_a;
  logic        tx_a, sclk_a, sdat_a, busy_a;
  logic [1:0]  gid_a;
  logic [7:0]  fcnt_a;

  // DUT B: CLK_DIV=2, GAP=0
  logic        rst_b = 1'b1;
  logic [3:0]  valid_b = '0;
  logic [63:0] data_b = '0;
  logic [3:0]  ready_b;
  logic        tx_b, sclk_b, sdat_b, busy_b;
  logic [1:0]  gid_b;
  logic [7:0]  fcnt_b;

  vive_tx_scheduler #(.NCH(4), .ID_W(2), .DW(16), .CLK_DIV(2), .GAP(4)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_data(data_a),
    .req_ready(ready_a), .transmission(tx_a), .clock(sclk_a), .data(sdat_a),
    .busy(busy_a), .grant_id(gid_a), .frame_cnt(fcnt_a)
  );

  vive_tx_scheduler #(.NCH(4), .ID_W(2), .DW(16), .CLK_DIV(2), .GAP(0)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_data(data_b),
    .req_ready(ready_b), .transmission(tx_b), .clock(sclk_b), .data(sdat_b),
    .busy(busy_b), .grant_id(gid_b), .frame_cnt(fcnt_b)
  );

  int total = 0;
  int bad   = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  function automatic logic [18:0] mk_frame(input logic [1:0] id, input logic [15:0] d);
    return {id, d, ^{id, d}};
  endfunction

  function automatic logic [15:0] wd(input int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  task automatic push_a(input logic [1:0] id, input logic [15:0] d);
    exp_t e;
    e.id = id;
    e.bits = mk_frame(id, d);
    sb_a.push_back(e);
  endtask

  // ---------------- monitor A ----------------
  logic        prev_tx_a = 0, prev_clk_a = 0, prev_dat_a = 0;
  int          tx_len_a = 0, nedge_a = 0, stab_a = 0, low_a = 0, frames_a = 0;
  logic [18:0] bits_a = '0;
  bit          gap_chk_a = 0, seen_fall_a = 0, abort_a = 0;
  exp_t        e_a;

  always @(negedge clk) begin
    if (tx_a) begin
      if (!prev_tx_a) begin
        if (gap_chk_a && seen_fall_a) begin
          total++;
          if (low_a !== 17) begin
            bad++;
            $display("FAIL gap_low_a: got %0d cycles want 17", low_a);
          end
        end
        tx_len_a = 0; nedge_a = 0; stab_a = 0; bits_a = '0;
      end
      tx_len_a++;
      if (sclk_a && !prev_clk_a) begin
        bits_a = {bits_a[17:0], sdat_a};
        nedge_a++;
      end
      if (sclk_a && prev_clk_a && (sdat_a !== prev_dat_a)) stab_a++;
    end else begin
      if (prev_tx_a) begin
        if (abort_a) begin
          abort_a = 0;
          seen_fall_a = 0;
          $display("frame A aborted after %0d cycles", tx_len_a);
        end else begin
          frames_a++;
          seen_fall_a = 1;
          total++;
          if (sb_a.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame_a: got id=%0d bits=%05h want none", gid_a, bits_a);
          end else begin
            e_a = sb_a.pop_front();
            $display("frame A id=%0d bits=%05h len=%0d", gid_a, bits_a, tx_len_a);
            if (bits_a !== e_a.bits) begin
              bad++;
              $display("FAIL frame_bits_a: got %05h want %05h", bits_a, e_a.bits);
            end
            total++;
            if (gid_a !== e_a.id) begin
              bad++;
              $display("FAIL grant_id_a: got %0d want %0d", gid_a, e_a.id);
            end
            total++;
            if (tx_len_a !== 76) begin
              bad++;
              $display("FAIL tx_len_a: got %0d want 76", tx_len_a);
            end
            total++;
            if (nedge_a !== 19) begin
              bad++;
              $display("FAIL clk_edges_a: got %0d want 19", nedge_a);
            end
            total++;
            if (stab_a !== 0) begin
              bad++;
              $display("FAIL data_stable_a: got %0d changes want 0", stab_a);
            end
          end
        end
        low_a = 0;
      end
      low_a++;
    end
    prev_tx_a  = tx_a;
    prev_clk_a = sclk_a;
    prev_dat_a = sdat_a;
  end

  // ---------------- monitor B ----------------
  logic        prev_tx_b = 0, prev_clk_b = 0;
  int          tx_len_b = 0, low_b = 0, frames_b = 0, max_fc_b = 0;
  logic [18:0] bits_b = '0;
  bit          seen_fall_b = 0;
  exp_t        e_b;

  always @(negedge clk) begin
    if (int'(fcnt_b) > max_fc_b) max_fc_b = int'(fcnt_b);
    if (tx_b) begin
      if (!prev_tx_b) begin
        if (seen_fall_b) begin
          total++;
          if (low_b !== 1) begin
            bad++;
            $display("FAIL gap_low_b: got %0d cycles want 1", low_b);
          end
        end
        tx_len_b = 0; bits_b = '0;
      end
      tx_len_b++;
      if (sclk_b && !prev_clk_b) bits_b = {bits_b[17:0], sdat_b};
    end else begin
      if (prev_tx_b) begin
        frames_b++;
        seen_fall_b = 1;
        total++;
        if (sb_b.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame_b: got bits=%05h want none", bits_b);
        end else begin
          e_b = sb_b.pop_front();
          $display("frame B #%0d id=%0d bits=%05h cnt=%0d", frames_b, gid_b, bits_b, fcnt_b);
          if ((bits_b !== e_b.bits) || (gid_b !== e_b.id) || (tx_len_b !== 76)) begin
            bad++;
            $display("FAIL frame_b: got id=%0d bits=%05h len=%0d want id=%0d bits=%05h len=76",
                     gid_b, bits_b, tx_len_b, e_b.id, e_b.bits);
          end
        end
        low_b = 0;
      end
      low_b++;
    end
    prev_tx_b  = tx_b;
    prev_clk_b = sclk_b;
  end

  // ---------------- requester model for DUT A ----------------
  logic [15:0] ch_d [4][4];
  int          ch_n [4];
  int          ch_p [4];
  logic [3:0]  xtra = '0;
  logic [3:0]  rdy_s = '0, val_s = '0;

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      ch_n[k] = 0;
      ch_p[k] = 0;
    end
    xtra = '0;
  endtask

  task automatic load_ch(input int k, input logic [15:0] d);
    ch_d[k][ch_n[k]] = d;
    ch_n[k]++;
  endtask

  task automatic apply_model();
    for (int k = 0; k < 4; k++) begin
      if (ch_p[k] < ch_n[k]) begin
        valid_a[k] = 1'b1;
        data_a[k*16 +: 16] = ch_d[k][ch_p[k]];
      end else begin
        valid_a[k] = xtra[k];
        data_a[k*16 +: 16] = 16'hDEAD;
      end
    end
  endtask

  task automatic sync_model();
    apply_model();
    #1;
    rdy_s = ready_a;
    val_s = valid_a;
  endtask

  // One clock: retire the transfer seen at the edge, present the next request.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      if (rdy_s[k] && val_s[k]) ch_p[k]++;
    sync_model();
  endtask

  task automatic run_a(input int budget, input string name);
    int n = 0;
    while ((sb_a.size() > 0 || busy_a || tx_a) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: got %0d frames pending want 0", name, sb_a.size());
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    clear_model();
    apply_model();
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    seen_fall_a = 0;
    sync_model();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b1;
    valid_a = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready_a !== 4'b0000) begin
      bad++;
      $display("FAIL ready_in_rst: got %b want 0000", ready_a);
    end
    valid_a = '0;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({tx_a, sclk_a, sdat_a, busy_a} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_lines: got tx/clk/dat/busy=%b want 0000", {tx_a, sclk_a, sdat_a, busy_a});
    end
    total++;
    if (gid_a !== 2'd0) begin
      bad++;
      $display("FAIL reset_grant_id: got %0d want 0", gid_a);
    end
    total++;
    if (fcnt_a !== 8'd0) begin
      bad++;
      $display("FAIL reset_frame_cnt: got %0d want 0", fcnt_a);
    end
    total++;
    if (ready_a !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 0000", ready_a);
    end
  endtask

  task automatic test_single();
    exp_t e;
    clear_model();
    seen_fall_a = 0;
    load_ch(2, 16'hA5C3);
    e.id = 2'd2;
    e.bits = 19'b10_1010010111000011_1;
    sb_a.push_back(e);
    sync_model();
    total++;
    if (ready_a !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready: got %b want 0100", ready_a);
    end
    step();
    total++;
    if (ready_a !== 4'b0000) begin
      bad++;
      $display("FAIL single_ready_after: got %b want 0000", ready_a);
    end
    total++;
    if ({tx_a, busy_a, sdat_a, sclk_a} !== 4'b1110) begin
      bad++;
      $display("FAIL single_first_cycle: got tx/busy/dat/clk=%b want 1110", {tx_a, busy_a, sdat_a, sclk_a});
    end
    total++;
    if (gid_a !== 2'd2) begin
      bad++;
      $display("FAIL single_grant_id: got %0d want 2", gid_a);
    end
    step();
    total++;
    if (sclk_a !== 1'b0) begin
      bad++;
      $display("FAIL single_clk_low2: got %b want 0", sclk_a);
    end
    step();
    total++;
    if (sclk_a !== 1'b1) begin
      bad++;
      $display("FAIL single_clk_rise: got %b want 1", sclk_a);
    end
    run_a(400, "single");
    total++;
    if (fcnt_a !== 8'd1) begin
      bad++;
      $display("FAIL single_frame_cnt: got %0d want 1", fcnt_a);
    end
  endtask

  task automatic test_simultaneous();
    rst_a = 1'b1;
    clear_model();
    load_ch(0, 16'h1111);
    load_ch(0, 16'h2222);
    load_ch(1, 16'h3333);
    load_ch(3, 16'h4444);
    apply_model();
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    seen_fall_a = 0;
    push_a(2'd0, 16'h1111);
    push_a(2'd1, 16'h3333);
    push_a(2'd3, 16'h4444);
    push_a(2'd0, 16'h2222);
    gap_chk_a = 1;
    sync_model();
    run_a(2000, "simultaneous");
    gap_chk_a = 0;
  endtask

  task automatic test_fairness();
    reset_a();
    load_ch(0, 16'hAAAA);
    load_ch(0, 16'hBBBB);
    load_ch(1, 16'hCCCC);
    load_ch(1, 16'hDDDD);
    push_a(2'd0, 16'hAAAA);
    push_a(2'd1, 16'hCCCC);
    push_a(2'd0, 16'hBBBB);
    push_a(2'd1, 16'hDDDD);
    gap_chk_a = 1;
    sync_model();
    run_a(2000, "fairness");
    gap_chk_a = 0;
    total++;
    if (fcnt_a !== 8'd4) begin
      bad++;
      $display("FAIL fairness_frame_cnt: got %0d want 4", fcnt_a);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    clear_model();
    seen_fall_a = 0;
    load_ch(2, 16'h1234);
    sync_model();
    while (!tx_a && n < 50) begin
      step();
      n++;
    end
    total++;
    if (!tx_a) begin
      bad++;
      $display("FAIL midrst_start: got tx=%b want 1", tx_a);
    end
    // Now at T+1; bit 5 occupies T+21..T+24.
    repeat (21) step();
    abort_a = 1;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    total++;
    if ({tx_a, sclk_a, sdat_a, busy_a} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_lines: got tx/clk/dat/busy=%b want 0000", {tx_a, sclk_a, sdat_a, busy_a});
    end
    total++;
    if (fcnt_a !== 8'd0) begin
      bad++;
      $display("FAIL midrst_frame_cnt: got %0d want 0", fcnt_a);
    end
    // ch1 and ch3 together: a pointer back at 0 picks ch1 first.
    load_ch(1, 16'h0001);
    load_ch(3, 16'h00F0);
    push_a(2'd1, 16'h0001);
    push_a(2'd3, 16'h00F0);
    sync_model();
    run_a(2000, "midrst");
    total++;
    if (fcnt_a !== 8'd2) begin
      bad++;
      $display("FAIL midrst_frame_cnt_after: got %0d want 2", fcnt_a);
    end
  endtask

  task automatic test_transient();
    int n = 0;
    int fc0;
    int fr0;
    int rdy_bad = 0;
    int tx_bad = 0;
    clear_model();
    seen_fall_a = 0;
    fc0 = int'(fcnt_a);
    load_ch(0, 16'h0F0F);
    push_a(2'd0, 16'h0F0F);
    sync_model();
    while (!tx_a && n < 50) begin
      step();
      n++;
    end
    fr0 = frames_a;
    for (int c = 0; c < 60; c++) begin
      xtra[3] = (c >= 5 && c < 55);
      step();
      if (ready_a !== 4'b0000) rdy_bad++;
    end
    xtra = '0;
    apply_model();
    total++;
    if (rdy_bad !== 0) begin
      bad++;
      $display("FAIL transient_ready: got %0d ready cycles want 0", rdy_bad);
    end
    run_a(400, "transient");
    for (int c = 0; c < 60; c++) begin
      step();
      if (tx_a || busy_a) tx_bad++;
    end
    total++;
    if (tx_bad !== 0) begin
      bad++;
      $display("FAIL transient_extra_frame: got %0d busy cycles want 0", tx_bad);
    end
    total++;
    if (int'(fcnt_a) !== fc0 + 1 || frames_a !== fr0 + 1) begin
      bad++;
      $display("FAIL transient_frame_cnt: got %0d want %0d", fcnt_a, fc0 + 1);
    end
  endtask

  task automatic test_wrap_nogap();
    exp_t e;
    int g = 0;
    int n = 0;
    logic rs;
    for (int i = 0; i < 256; i++) begin
      e.id = 2'd0;
      e.bits = mk_frame(2'd0, wd(i));
      sb_b.push_back(e);
    end
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    seen_fall_b = 0;
    valid_b = 4'b0001;
    data_b[15:0] = wd(0);
    #1;
    rs = ready_b[0] & valid_b[0];
    while ((sb_b.size() > 0 || busy_b) && n < 30000) begin
      @(posedge clk);
      #1;
      if (rs) begin
        g++;
        if (g >= 256) valid_b = 4'b0000;
        else data_b[15:0] = wd(g);
      end
      #1;
      rs = ready_b[0] & valid_b[0];
      n++;
    end
    total++;
    if (n >= 30000) begin
      bad++;
      $display("FAIL wrap_timeout: got %0d frames pending want 0", sb_b.size());
    end
    total++;
    if (frames_b !== 256 || g !== 256) begin
      bad++;
      $display("FAIL wrap_frames: got %0d frames %0d grants want 256", frames_b, g);
    end
    total++;
    if (max_fc_b !== 255) begin
      bad++;
      $display("FAIL wrap_max_cnt: got %0d want 255", max_fc_b);
    end
    total++;
    if (fcnt_b !== 8'd0) begin
      bad++;
      $display("FAIL wrap_frame_cnt: got %0d want 0", fcnt_b);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_model();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_reset_midframe();
    test_transient();
    test_wrap_nogap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vive_tx_scheduler.md
Name: vive_tx_scheduler

Overview:
- Shares the serial link (transmission/clock/data) between NCH lighthouse sensor measurement channels.
- Round-robin arbitrates among the channels' valid/ready requests and latches one measurement per frame.
- Serialises each frame as channel id, measurement and parity, with an inter-frame gap.
- Sits between the per-sensor pulse timers and the top-level transmission, clock and data pins.

Parameters:
- NCH, 4, number of requesting sensor channels (2..2**ID_W).
- ID_W, 2, width of the channel-id header field.
- DW, 16, measurement width per channel.
- CLK_DIV, 8, system clocks per serial clock half-period (>=1).
- GAP, 4, idle serial bit times between frames (0 = no gap state).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel measurement available.
- req_data  in  NCH*DW  channel i occupies bits [i*DW +: DW].
- req_ready  out  NCH  one-hot grant; transfer when valid&ready at a clk edge.
- transmission  out  1  high for the duration of a frame.
- clock  out  1  serial clock.
- data  out  1  serial data, MSB first.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  ID_W  id of the channel currently or last transmitted.
- frame_cnt  out  8  completed frames; wraps 255->0.

Behaviour:
- Reset values: state IDLE, round-robin pointer 0; transmission, clock, data, busy, grant_id and frame_cnt all 0.
- States: IDLE -> SHIFT -> GAP -> IDLE. GAP is skipped (SHIFT -> IDLE) when GAP=0.
- IDLE, arbitration:
  - Search order is ptr, ptr+1, ... mod NCH; first channel with req_valid=1 wins.
  - req_ready is combinational: one-hot of the winner, only in IDLE; zero in all other states and during rst.
  - Transfer edge T: latch req_data[winner], grant_id=winner, ptr=(winner+1) mod NCH, go to SHIFT.
  - No valid: stay in IDLE, outputs low.
- Requesters must hold valid and data until ready. Dropping valid before grant is legal; the channel is simply skipped.
- Frame format: NBITS = ID_W+DW+1.
  - grant_id MSB first, then measurement MSB first.
  - Then an even parity bit = XOR of all id and data bits.
- SHIFT timing:
  - At T+1: transmission=1, busy=1, data=first bit, clock=0.
  - Each bit lasts 2*CLK_DIV cycles: clock low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - data changes only on cycles where clock is low, at the bit boundary; it is stable while clock is high.
  - The first rising edge of clock is at T+1+CLK_DIV.
- End of frame:
  - After the high phase of bit NBITS-1, at cycle T+1+NBITS*2*CLK_DIV: transmission=0, clock=0, data=0, frame_cnt+1, enter GAP.
- GAP:
  - Lasts GAP*2*CLK_DIV cycles with transmission, clock and data low and busy=1; then IDLE.
  - Earliest next transfer edge is the first IDLE cycle, so the line is low for at least GAP*2*CLK_DIV+1 cycles.
- Counters: bit counter and divider are internal and sized for NBITS and CLK_DIV. frame_cnt wraps modulo 256 silently.
- Reset mid-frame or mid-gap:
  - The next cycle has all outputs at reset values and state IDLE.
  - The frame is aborted; the receiver sees transmission fall early. frame_cnt is cleared, not incremented.
  - The latched measurement is discarded; the requester is not re-granted automatically.
- New requests arriving during SHIFT/GAP wait; req_ready stays 0.
- Simultaneous valids are resolved purely by the pointer. No channel waits more than NCH-1 frames.

Test Plan:
- Single request (CLK_DIV=2, GAP=4): ch2 valid, data 0xA5C3.
  - req_ready=0100 for one cycle; transmission high exactly 76 cycles.
  - data bits = 10 1010010111000011 1 (parity 1); 19 clock rising edges; frame_cnt=1.
- Simultaneous ch0, ch1, ch3 valid held from reset:
  - Grant order 0,1,3, then ch0 re-requested is granted next.
  - grant_id sequence 0,1,3,0.
- Fairness: ch0 and ch1 continuously valid -> frames alternate 0,1,0,1.
  - Line low between frames exactly 17 cycles (GAP=4, CLK_DIV=2).
- Reset mid-frame: rst for one cycle during bit 5.
  - Next cycle transmission/clock/data/busy=0, frame_cnt=0.
  - A later ch1 request (data 0x0001) produces a full correct 19-bit frame from ptr 0.
- Transient valid: ch3 valid asserted during SHIFT and dropped before IDLE -> ch3 never granted, no extra frame.
- Wrap and no-gap: GAP=0, 256 back-to-back frames.
  - frame_cnt wraps to 0.
  - transmission low exactly 1 cycle between frames.
